// File: rtl/mips_int_ctrl_pkg.sv
// mips_int_ctrl_pkg: register map, bit positions and source indices for the interrupt controller
package mips_int_ctrl_pkg;
  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_CTRL = 2'd1,
    REG_EDGE = 2'd2,
    REG_STAT = 2'd3
  } reg_e;
  localparam int GIE_BIT = 8;
  localparam int OVF_LSB = 8;
  localparam int VALID_BIT = 7;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F30;
  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;
  localparam int SRC_EXT = 2;
endpackage

// File: rtl/mips_int_prienc.sv
// mips_int_prienc: lowest-index-wins priority encoder, vec forced to 0 when nothing requests
module mips_int_prienc #(
  parameter int N = 6
) (
  input  logic [N-1:0] i_req,
  output logic [2:0]   o_vec,
  output logic         o_valid
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    o_vec = 3'd0;
    for (int i = N - 1; i >= 0; i--) o_vec = i_req[i] ? 3'(i) : o_vec;
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl: memory-mapped interrupt controller driving CP0 HWInt[7:2]
module mips_int_ctrl
  import mips_int_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          N_SRC     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic [N_SRC-1:0] irq_src,
  output logic [5:0]       hw_int
);
  logic [N_SRC-1:0] r_pend, r_mask, r_edge, r_ovf, r_prev;
  logic             r_gie;
  reg_e             w_sel;
  logic [N_SRC-1:0] w_set, w_clr, w_ovf_set, w_ovf_clr, w_act;
  logic [2:0]       w_vec;
  logic             w_valid;
  logic             w_unused;

  assign w_sel     = reg_e'(addr[3:2]);
  assign w_set     = irq_src & ~(r_edge & r_prev);
  assign w_clr     = (we && w_sel == REG_PEND) ? wd[N_SRC-1:0] : '0;
  assign w_ovf_set = w_set & r_edge & r_pend;
  assign w_ovf_clr = (we && w_sel == REG_STAT) ? wd[OVF_LSB +: N_SRC] : '0;
  assign w_act     = r_pend & r_mask;
  assign hw_int    = 6'(w_act & {N_SRC{r_gie}});
  assign w_unused  = ^{BASE_ADDR, addr, wd};

  mips_int_prienc #(.N(N_SRC)) u_prienc (
    .i_req   (w_act),
    .o_vec   (w_vec),
    .o_valid (w_valid)
  );

  // register state; a new set always wins over a same-cycle clear so no event is lost
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_ovf  <= '0;
      r_prev <= '0;
      r_gie  <= 1'b0;
    end else begin
      r_prev <= irq_src;
      r_pend <= w_set | (r_pend & ~w_clr);
      r_ovf  <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      if (we && w_sel == REG_CTRL) begin
        r_mask <= wd[N_SRC-1:0];
        r_gie  <= wd[GIE_BIT];
      end
      if (we && w_sel == REG_EDGE) r_edge <= wd[N_SRC-1:0];
    end
  end

  // read mux over the four registers; unimplemented bits read 0
  always_comb begin
    rd = (w_sel == REG_PEND) ? {26'd0, 6'(r_pend)} :
         (w_sel == REG_CTRL) ? {23'd0, r_gie, 2'd0, 6'(r_mask)} :
         (w_sel == REG_EDGE) ? {26'd0, 6'(r_edge)} :
                               {18'd0, 6'(r_ovf), w_valid, 4'd0, w_vec};
  end
endmodule

// File: tb/tb_mips_int_ctrl.sv
// tb_mips_int_ctrl: directed-vector bench for the interrupt controller
module tb_mips_int_ctrl;
  localparam logic [31:0] BASE = 32'h0000_7F30;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  irq_src;
  logic [5:0]  hw_int;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mips_int_ctrl #(.BASE_ADDR(BASE), .N_SRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .irq_src (irq_src),
    .hw_int  (hw_int)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    addr = BASE + {28'd0, off, 2'b00};
    wd = d;
    we = 1'b1;
    tick();
    we = 1'b0;
    wd = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] v);
    addr = BASE + {28'd0, off, 2'b00};
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    irq_src = 6'h3F;
    we = 1'b1;
    wd = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        addr = BASE + 32'(k * 4);
        #1;
        v = rd;
        n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL reset_rd%0d cyc%0d got %h want 00000000", k, c, v); end
        n_vec++;
        if (hw_int !== 6'h00) begin n_err++; $display("FAIL reset_hwint cyc%0d got %h want 00", c, hw_int); end
      end
    end
    we = 1'b0;
    wd = 32'd0;
    irq_src = 6'h00;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_level();
    logic [31:0] v;
    wr(2'd1, 32'h0000_0102);
    irq_src = 6'h02;
    tick();
    irq_src = 6'h00;
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h02) begin n_err++; $display("FAIL level_pend got %h want 00000002", v); end
    n_vec++;
    if (hw_int !== 6'h02) begin n_err++; $display("FAIL level_hwint got %h want 02", hw_int); end
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h81) begin n_err++; $display("FAIL level_stat got %h want 00000081", v); end
    wr(2'd0, 32'h02);
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL level_w1c got %h want 00000000", v); end
    n_vec++;
    if (hw_int !== 6'h00) begin n_err++; $display("FAIL level_w1c_hwint got %h want 00", hw_int); end
  endtask

  task automatic test_edge_ovf();
    logic [31:0] v;
    wr(2'd2, 32'h04);
    wr(2'd1, 32'h104);
    for (int p = 0; p < 2; p++) begin
      irq_src = 6'h04;
      tick();
      irq_src = 6'h00;
      tick();
    end
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h04) begin n_err++; $display("FAIL edge_pend got %h want 00000004", v); end
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h482) begin n_err++; $display("FAIL edge_ovf_stat got %h want 00000482", v); end
    n_vec++;
    if (hw_int !== 6'h04) begin n_err++; $display("FAIL edge_hwint got %h want 04", hw_int); end
    wr(2'd3, 32'h0000_00FF);
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h482) begin n_err++; $display("FAIL stat_low_wr got %h want 00000482", v); end
    wr(2'd3, 32'h0000_0400);
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h82) begin n_err++; $display("FAIL ovf_w1c got %h want 00000082", v); end
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h04) begin n_err++; $display("FAIL ovf_w1c_pend got %h want 00000004", v); end
    wr(2'd0, 32'h3F);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    wr(2'd2, 32'h01);
    wr(2'd1, 32'h101);
    irq_src = 6'h01;
    addr = BASE;
    wd = 32'h01;
    we = 1'b1;
    tick();
    we = 1'b0;
    wd = 32'd0;
    irq_src = 6'h00;
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h01) begin n_err++; $display("FAIL set_vs_clr got %h want 00000001", v); end
    tick();
    irq_src = 6'h01;
    addr = BASE + 32'hC;
    wd = 32'h100;
    we = 1'b1;
    tick();
    we = 1'b0;
    wd = 32'd0;
    irq_src = 6'h00;
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h180) begin n_err++; $display("FAIL ovf_set_vs_clr got %h want 00000180", v); end
    wr(2'd3, 32'h100);
    wr(2'd0, 32'h01);
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL collision_cleanup got %h want 00000000", v); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h3F);
    irq_src = 6'h06;
    tick();
    n_vec++;
    if (hw_int !== 6'h00) begin n_err++; $display("FAIL prio_gie_off_hwint got %h want 00", hw_int); end
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h81) begin n_err++; $display("FAIL prio_vec1 got %h want 00000081", v); end
    wr(2'd1, 32'h13F);
    n_vec++;
    if (hw_int !== 6'h06) begin n_err++; $display("FAIL prio_gie_on_hwint got %h want 06", hw_int); end
    wr(2'd1, 32'h13D);
    read_reg(2'd3, v);
    n_vec++;
    if (v !== 32'h82) begin n_err++; $display("FAIL prio_vec2 got %h want 00000082", v); end
    n_vec++;
    if (hw_int !== 6'h04) begin n_err++; $display("FAIL prio_mask_hwint got %h want 04", hw_int); end
    irq_src = 6'h00;
    wr(2'd0, 32'h3F);
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL prio_cleanup got %h want 00000000", v); end
  endtask

  task automatic test_mode_switch();
    logic [31:0] v;
    wr(2'd1, 32'h108);
    irq_src = 6'h08;
    tick();
    wr(2'd2, 32'h08);
    wr(2'd0, 32'h08);
    tick();
    tick();
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL mode_held_pend got %h want 00000000", v); end
    n_vec++;
    if (hw_int !== 6'h00) begin n_err++; $display("FAIL mode_held_hwint got %h want 00", hw_int); end
    irq_src = 6'h00;
    tick();
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL mode_fall_pend got %h want 00000000", v); end
    irq_src = 6'h08;
    tick();
    read_reg(2'd0, v);
    n_vec++;
    if (v !== 32'h08) begin n_err++; $display("FAIL mode_rise_pend got %h want 00000008", v); end
    n_vec++;
    if (hw_int !== 6'h08) begin n_err++; $display("FAIL mode_rise_hwint got %h want 08", hw_int); end
    irq_src = 6'h00;
    wr(2'd0, 32'h08);
  endtask

  task automatic test_regmap();
    logic [31:0] v;
    wr(2'd1, 32'hFFFF_FFFF);
    read_reg(2'd1, v);
    n_vec++;
    if (v !== 32'h13F) begin n_err++; $display("FAIL ctrl_readback got %h want 0000013F", v); end
    wr(2'd2, 32'hFFFF_FFFF);
    read_reg(2'd2, v);
    n_vec++;
    if (v !== 32'h3F) begin n_err++; $display("FAIL edge_readback got %h want 0000003F", v); end
    wr(2'd1, 32'h0);
    read_reg(2'd1, v);
    n_vec++;
    if (v !== 32'h0) begin n_err++; $display("FAIL ctrl_clear got %h want 00000000", v); end
  endtask

  initial begin
    reset = 1'b0;
    addr = BASE;
    we = 1'b0;
    wd = 32'd0;
    irq_src = 6'h00;
    test_reset();
    test_level();
    test_edge_ovf();
    test_collision();
    test_priority();
    test_mode_switch();
    test_regmap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
